seq_alu_param: RTL and testbench
================================

// Module: seq_alu_param
// PURPOSE
//  Parametrised, single-clock sequential ALU that succeeds the two-edge opcode ALU.
//  Registered operands, valid/ready handshakes on input and output, and an iterative
//  multi-cycle divider. An accumulator register lets results feed back as operand A.
//  Sits between an operation issuer and a result consumer in datapath experiments.
// PARAMETERS
//  WIDTH    4   operand/result width in bits (>=2)
//  ACC_INIT 0   accumulator value after reset
// PORTS
//  clk          in   1      rising-edge clock; sole clock
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operation request valid
//  in_ready     out  1      block can accept a request
//  op           in   3      opcode (see BEHAVIOUR)
//  acc_sel      in   1      1: operand A = accumulator; 0: operand A = a
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  result       out  WIDTH  operation result
//  carry        out  1      ADD carry-out / SUB borrow / MUL overflow; 0 otherwise
//  zero         out  1      result == 0
//  div_by_zero  out  1      DIV with b == 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; result, carry, zero, div_by_zero and
//    out_valid are 0; acc=ACC_INIT. Any divide in progress is aborted and its result is discarded.
//  - Opcodes: 000 PASS(A), 001 ADD, 010 SUB (A-b mod 2^WIDTH), 011 DIV (A/b unsigned),
//    100 MUL (low WIDTH bits), 101 OR, 110 XOR, 111 AND. All operations are unsigned.
//  - FSM: IDLE, DIV, HOLD.
//    - IDLE: in_ready=1. Accept on in_valid&&in_ready, and capture op, A and b.
//      Non-DIV op, or DIV with b==0: the result is registered at the accept edge, and the next state is HOLD.
//      DIV with b!=0: the next state is DIV.
//    - DIV: restoring divider, one quotient bit per cycle, for WIDTH cycles.
//      After the final bit, the next state is HOLD. in_ready=0.
//    - HOLD: out_valid=1. result and flags are stable until the handshake.
//      On out_valid&&out_ready: acc<=result, and the next state is IDLE.
//  - in_ready is 1 only in IDLE. A new request is never accepted in the same cycle as
//    an output handshake. Sustained throughput is at most one op per 2 cycles.
//  - Latency from accept edge N to out_valid high:
//    - non-DIV op or b==0: edge N+1
//    - DIV with b!=0: edge N+WIDTH+1
//  - DIV with b==0: result={WIDTH{1}}, div_by_zero=1, carry=0.
//    div_by_zero is 0 for every other result.
//  - carry:
//    - ADD: bit WIDTH of the (WIDTH+1)-bit sum
//    - SUB: 1 when A<b
//    - MUL: 1 when any of the upper WIDTH bits of the 2*WIDTH product is nonzero
//    - all other ops: 0
//  - zero is computed from the registered result, including DIV by zero (=0).
//  - acc_sel is sampled only at accept. When acc_sel=1, the a input is ignored.
//  - acc updates only on the output handshake. A result that is dropped by reset never updates acc.
//  - Inputs while in_ready=0 are ignored; no request is queued.
// TESTING (WIDTH=4)
//  - ADD a=9,b=8, out_ready=1 -> out_valid 1 cycle after accept; result=1, carry=1, zero=0.
//  - DIV a=13,b=3 -> out_valid exactly 5 cycles after accept; result=4; in_ready=0 throughout.
//  - DIV a=7,b=0 -> 1 cycle later: result=4'hF, div_by_zero=1, carry=0.
//  - SUB a=2,b=5 with out_ready held 0 for 3 cycles -> result=4'hD, carry=1, stable;
//    in_ready stays 0 and a second in_valid is not accepted until after the handshake.
//  - ADD a=3,b=2 accepted and handshaken, then acc_sel=1 MUL b=4 -> result=4 (20 mod 16), carry=1.
//  - rst pulsed 2 cycles into DIV a=15,b=2 -> the next cycle shows IDLE, out_valid=0,
//    result=0 and acc=ACC_INIT; a subsequent PASS a=6 returns 6.

Source files
------------

// File: rtl/seq_alu_param_if.sv
// Request/response bundle between an operation issuer (master) and the
// sequential ALU (slave).
interface seq_alu_param_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, op, acc_sel, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, acc_sel, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu_param.sv
// Sequential ALU with valid/ready handshakes, an accumulator that can feed
// back as operand A, and an iterative restoring divider (one bit per cycle).
module seq_alu_param #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  seq_alu_param_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_HOLD
  } state_e;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MUL  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_AND  = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divb_q, divb_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  op_e              op_in;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  assign op_in = op_e'(bus.op);
  assign opa   = bus.acc_sel ? acc_q : bus.a;
  assign sum   = {1'b0, opa} + {1'b0, bus.b};
  assign diff  = {1'b0, opa} - {1'b0, bus.b};
  assign prod  = W2'(opa) * W2'(bus.b);

  // Single-cycle operations, evaluated on the operands presented at accept.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_in)
      OP_PASS: alu_res = opa;
      OP_ADD:  begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB:  begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_DIV:  alu_res = '1;
      OP_MUL:  begin alu_res = prod[WIDTH-1:0]; alu_carry = |prod[W2-1:WIDTH]; end
      OP_OR:   alu_res = opa | bus.b;
      OP_XOR:  alu_res = opa ^ bus.b;
      OP_AND:  alu_res = opa & bus.b;
      default: alu_res = '0;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, try subtract.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divb_q};
  assign q_bit  = ~trial[WIDTH];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    divb_d   = divb_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (op_in == OP_DIV && bus.b != '0) begin
            quo_d   = opa;
            rem_d   = '0;
            divb_d  = bus.b;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_DIV;
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            dbz_d    = (op_in == OP_DIV);
            state_d  = S_HOLD;
          end
        end
      end
      S_DIV: begin
        rem_d = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], q_bit};
        if (cnt_q == '0) begin
          result_d = quo_d;
          carry_d  = 1'b0;
          zero_d   = (quo_d == '0);
          dbz_d    = 1'b0;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          acc_d   = result_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      acc_q    <= ACC_INIT;
      rem_q    <= '0;
      quo_q    <= '0;
      divb_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      divb_q   <= divb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_HOLD);
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed bench for seq_alu_param (WIDTH=4): vector table plus hand-written
// sequences for back-pressure, accumulator chaining and reset during divide.
module tb_seq_alu_param;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_alu_param_if #(.WIDTH(WIDTH)) bus_if ();

  seq_alu_param #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic sel,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic c, input logic z,
                        input logic dbz, input int lat);
    int n;
    int cyc;
    logic busy;
    @(negedge clk);
    n = 0;
    while (!bus_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, ".in_ready"}, 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.op       = op;
    bus_if.acc_sel  = sel;
    bus_if.a        = a;
    bus_if.b        = b;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.a        = ~a;
    bus_if.b        = ~b;
    @(negedge clk);
    cyc  = 1;
    busy = 1'b0;
    while (!bus_if.out_valid && cyc < 40) begin
      if (bus_if.in_ready) busy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, ".latency"}, 32'(cyc), 32'(lat));
    check({name, ".in_ready_busy"}, 32'(busy), 32'd0);
    check({name, ".result"}, 32'(bus_if.result), 32'(res));
    check({name, ".carry"}, 32'(bus_if.carry), 32'(c));
    check({name, ".zero"}, 32'(bus_if.zero), 32'(z));
    check({name, ".dbz"}, 32'(bus_if.div_by_zero), 32'(dbz));
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    logic stray;
    total = 0;
    bad   = 0;

    //                op     a      b      res    c  z  dbz lat
    vecs[0]  = '{3'd1, 4'd9,  4'd8,  4'd1,  1, 0, 0, 1};  // ADD carry-out
    vecs[1]  = '{3'd1, 4'd3,  4'd4,  4'd7,  0, 0, 0, 1};
    vecs[2]  = '{3'd2, 4'd2,  4'd5,  4'hD,  1, 0, 0, 1};  // SUB borrow
    vecs[3]  = '{3'd2, 4'd5,  4'd5,  4'd0,  0, 1, 0, 1};
    vecs[4]  = '{3'd3, 4'd13, 4'd3,  4'd4,  0, 0, 0, 5};  // DIV iterative
    vecs[5]  = '{3'd3, 4'd7,  4'd0,  4'hF,  0, 0, 1, 1};  // DIV by zero
    vecs[6]  = '{3'd3, 4'd2,  4'd7,  4'd0,  0, 1, 0, 5};
    vecs[7]  = '{3'd3, 4'd15, 4'd1,  4'hF,  0, 0, 0, 5};
    vecs[8]  = '{3'd4, 4'd5,  4'd3,  4'hF,  0, 0, 0, 1};
    vecs[9]  = '{3'd4, 4'd4,  4'd5,  4'd4,  1, 0, 0, 1};  // MUL overflow
    vecs[10] = '{3'd4, 4'd0,  4'd7,  4'd0,  0, 1, 0, 1};
    vecs[11] = '{3'd5, 4'hC,  4'h3,  4'hF,  0, 0, 0, 1};
    vecs[12] = '{3'd6, 4'hF,  4'h5,  4'hA,  0, 0, 0, 1};
    vecs[13] = '{3'd7, 4'hC,  4'hA,  4'h8,  0, 0, 0, 1};
    vecs[14] = '{3'd7, 4'h5,  4'hA,  4'h0,  0, 1, 0, 1};
    vecs[15] = '{3'd0, 4'd6,  4'd9,  4'd6,  0, 0, 0, 1};  // PASS ignores b

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.op        = '0;
    bus_if.acc_sel   = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst.result", 32'(bus_if.result), 32'd0);
    check("rst.carry", 32'(bus_if.carry), 32'd0);
    check("rst.zero", 32'(bus_if.zero), 32'd0);
    check("rst.dbz", 32'(bus_if.div_by_zero), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, 1'b0, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].dbz, vecs[i].lat);
    end

    // Back-pressure: SUB held for 3 cycles while a second request waits.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.op       = 3'd2;
    bus_if.acc_sel  = 1'b0;
    bus_if.a        = 4'd2;
    bus_if.b        = 4'd5;
    @(posedge clk);
    #1;
    bus_if.op = 3'd1;
    bus_if.a  = 4'd1;
    bus_if.b  = 4'd1;
    @(negedge clk);
    check("hold.out_valid", 32'(bus_if.out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d.result", k), 32'(bus_if.result), 32'hD);
      check($sformatf("hold%0d.carry", k), 32'(bus_if.carry), 32'd1);
      check($sformatf("hold%0d.out_valid", k), 32'(bus_if.out_valid), 32'd1);
      check($sformatf("hold%0d.in_ready", k), 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    check("after_hs.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("after_hs.in_ready", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    check("queued.out_valid", 32'(bus_if.out_valid), 32'd1);
    check("queued.result", 32'(bus_if.result), 32'd2);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;

    // Accumulator chaining: acc=5, then acc*4=20 mod 16, then acc-1.
    run_op("chain_add", 3'd1, 1'b0, 4'd3, 4'd2, 4'd5, 0, 0, 0, 1);
    run_op("chain_mul", 3'd4, 1'b1, 4'd9, 4'd4, 4'd4, 1, 0, 0, 1);
    run_op("chain_sub", 3'd2, 1'b1, 4'd0, 4'd1, 4'd3, 0, 0, 0, 1);

    // Reset two cycles into a divide aborts it and restores the accumulator.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.op       = 3'd3;
    bus_if.acc_sel  = 1'b0;
    bus_if.a        = 4'd15;
    bus_if.b        = 4'd2;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort.in_ready", 32'(bus_if.in_ready), 32'd1);
    check("abort.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("abort.result", 32'(bus_if.result), 32'd0);
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus_if.out_valid) stray = 1'b1;
    end
    check("abort.no_stray", 32'(stray), 32'd0);
    run_op("abort_acc", 3'd0, 1'b1, 4'd9, 4'd0, 4'd0, 0, 1, 0, 1);
    run_op("abort_pass", 3'd0, 1'b0, 4'd6, 4'd0, 4'd6, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
